// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_e;

  localparam int unsigned MDU_ITER = 32;
  localparam logic [4:0]  MDU_LAST_CNT = 5'(MDU_ITER - 1);

  function automatic logic [31:0] neg32(input logic n, input logic [31:0] v);
    return n ? (32'd0 - v) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic n, input logic [63:0] v);
    return n ? (64'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module mdu_step (
  input  logic        is_div,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [31:0] opnd,
  output logic [31:0] hi_nxt,
  output logic [31:0] lo_nxt
);

  logic [32:0] lhs;
  logic [32:0] rhs;
  logic        cin;
  logic [33:0] sum;

  // Divide subtracts via inverted operand plus carry-in; sum[33] is "no borrow".
  always_comb begin
    if (is_div) begin
      lhs = {hi, lo[31]};
      rhs = ~{1'b0, opnd};
      cin = 1'b1;
    end else begin
      lhs = {1'b0, hi};
      rhs = lo[0] ? {1'b0, opnd} : 33'd0;
      cin = 1'b0;
    end
    sum = {1'b0, lhs} + {1'b0, rhs} + {33'd0, cin};
  end

  always_comb begin
    if (is_div) begin
      hi_nxt = sum[33] ? sum[31:0] : lhs[31:0];
      lo_nxt = {lo[30:0], sum[33]};
    end else begin
      hi_nxt = sum[32:1];
      lo_nxt = {sum[0], lo[31:1]};
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO result registers.
module mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HIWr,
  input  logic        LOWr,
  input  logic [31:0] WD,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_e  state_q;
  mdu_op_e     op_q;
  logic [4:0]  cnt_q;
  logic [31:0] opnd_q;
  logic [31:0] acc_hi_q;
  logic [31:0] acc_lo_q;
  logic        neg_res_q;
  logic        neg_rem_q;
  logic        dbz_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  mdu_op_e     op_in;
  logic        signed_in;
  logic        div_in;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  logic        div_q;
  logic [31:0] step_hi;
  logic [31:0] step_lo;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_comb begin
    op_in     = mdu_op_e'(op);
    signed_in = (op_in == MDU_MULT) || (op_in == MDU_DIV);
    div_in    = (op_in == MDU_DIV) || (op_in == MDU_DIVU);
    a_neg     = signed_in & A[31];
    b_neg     = signed_in & B[31];
    a_mag     = neg32(a_neg, A);
    b_mag     = neg32(b_neg, B);
  end

  assign div_q = (op_q == MDU_DIV) || (op_q == MDU_DIVU);

  mdu_step u_step (
    .is_div (div_q),
    .hi     (acc_hi_q),
    .lo     (acc_lo_q),
    .opnd   (opnd_q),
    .hi_nxt (step_hi),
    .lo_nxt (step_lo)
  );

  // Remainder takes the dividend's sign; divide-by-zero quotient is forced to all ones.
  always_comb begin
    prod   = neg64(neg_res_q, {acc_hi_q, acc_lo_q});
    quo    = dbz_q ? 32'hFFFF_FFFF : neg32(neg_res_q, acc_lo_q);
    rem    = neg32(neg_rem_q, acc_hi_q);
    res_hi = div_q ? rem : prod[63:32];
    res_lo = div_q ? quo : prod[31:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= MDU_MULT;
      cnt_q     <= 5'd0;
      opnd_q    <= 32'd0;
      acc_hi_q  <= 32'd0;
      acc_lo_q  <= 32'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q      <= op_in;
            opnd_q    <= div_in ? b_mag : a_mag;
            acc_hi_q  <= 32'd0;
            acc_lo_q  <= div_in ? a_mag : b_mag;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dbz_q     <= div_in && (B == 32'd0);
            cnt_q     <= 5'd0;
            state_q   <= ST_CALC;
          end else begin
            if (HIWr) hi_q <= WD;
            if (LOWr) lo_q <= WD;
          end
        end
        ST_CALC: begin
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == MDU_LAST_CNT) state_q <= ST_FIX;
        end
        ST_FIX: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed table, corner sequences and randomized ops vs. arithmetic model.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        HIWr = 1'b0;
  logic        LOWr = 1'b0;
  logic [31:0] WD = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_chk = 0;
  int n_fail = 0;

  mdu dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .A    (A),
    .B    (B),
    .HIWr (HIWr),
    .LOWr (LOWr),
    .WD   (WD),
    .busy (busy),
    .done (done),
    .HI   (HI),
    .LO   (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic with the architectural corner rules.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = 32'd0;
    el = 32'd0;
    case (o)
      2'b00: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; end
      2'b10: begin
        if (b == 32'd0) begin eh = a; el = 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; el = 32'(q); eh = 32'(r); end
      end
      default: begin
        if (b == 32'd0) begin eh = a; el = 32'hFFFF_FFFF; end
        else begin el = a / b; eh = a % b; end
      end
    endcase
  endtask

  task automatic wait_idle(output int lat);
    lat = 0;
    while (busy && lat < 100) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int lat;
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(lat);
    chk({name, " latency"}, 64'(lat), 64'd33);
    chk({name, " done"}, 64'(done), 64'd1);
    chk({name, " HI"}, 64'(HI), 64'(eh));
    chk({name, " LO"}, 64'(LO), 64'(el));
    @(negedge clk);
    chk({name, " done pulse"}, 64'(done), 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    int lat;
    logic [31:0] eh, el, ra, rb;
    logic [1:0] ro;

    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF});
    vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF});
    vecs.push_back('{2'b11, 32'd100,       32'd7,         32'd2,         32'd14});
    vecs.push_back('{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    vecs.push_back('{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
    vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC});
    vecs.push_back('{2'b00, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000});

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset HI", 64'(HI), 64'd0);
    chk("reset LO", 64'(LO), 64'd0);
    rst = 1'b0;

    // MTHI/MTLO together, then MTHI alone
    @(negedge clk);
    HIWr = 1'b1; LOWr = 1'b1; WD = 32'hA5A5_A5A5;
    @(negedge clk);
    HIWr = 1'b0; LOWr = 1'b0;
    chk("mt both HI", 64'(HI), 64'hA5A5_A5A5);
    chk("mt both LO", 64'(LO), 64'hA5A5_A5A5);
    HIWr = 1'b1; WD = 32'h1111_1111;
    @(negedge clk);
    HIWr = 1'b0;
    chk("mthi HI", 64'(HI), 64'h1111_1111);
    chk("mthi LO kept", 64'(LO), 64'hA5A5_A5A5);

    // start beats MT writes in the same cycle; HI/LO hold during the operation
    op = 2'b01; A = 32'd2; B = 32'd3; start = 1'b1;
    HIWr = 1'b1; LOWr = 1'b1; WD = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; HIWr = 1'b0; LOWr = 1'b0;
    chk("start prio busy", 64'(busy), 64'd1);
    repeat (10) @(negedge clk);
    chk("hold HI", 64'(HI), 64'h1111_1111);
    chk("hold LO", 64'(LO), 64'hA5A5_A5A5);
    wait_idle(lat);
    chk("start prio HI", 64'(HI), 64'd0);
    chk("start prio LO", 64'(LO), 64'd6);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // start/HIWr/LOWr pulsed mid-operation must be ignored and not queued
    @(negedge clk);
    op = 2'b11; A = 32'd100; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (busy && lat < 100) begin
      lat++;
      if (lat == 5) begin
        start = 1'b1; HIWr = 1'b1; LOWr = 1'b1; WD = 32'h1234_5678;
        op = 2'b01; A = 32'd3; B = 32'd3;
      end else begin
        start = 1'b0; HIWr = 1'b0; LOWr = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; HIWr = 1'b0; LOWr = 1'b0;
    chk("ignore latency", 64'(lat), 64'd33);
    chk("ignore HI", 64'(HI), 64'd2);
    chk("ignore LO", 64'(LO), 64'd14);
    @(negedge clk);
    chk("ignore no queue", 64'(busy), 64'd0);

    // reset mid-operation aborts immediately
    op = 2'b01; A = 32'd5; B = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort HI", 64'(HI), 64'd0);
    chk("abort LO", 64'(LO), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after reset", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30);

    // back-to-back: start accepted in the done cycle
    @(negedge clk);
    op = 2'b01; A = 32'd3; B = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(lat);
    chk("b2b first done", 64'(done), 64'd1);
    chk("b2b first LO", 64'(LO), 64'd12);
    op = 2'b01; A = 32'd5; B = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b accepted", 64'(busy), 64'd1);
    chk("b2b done low", 64'(done), 64'd0);
    wait_idle(lat);
    chk("b2b latency", 64'(lat), 64'd33);
    chk("b2b HI", 64'(HI), 64'd0);
    chk("b2b LO", 64'(LO), 64'd25);

    // randomized ops vs. model
    for (int k = 0; k < 40; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = $urandom_range(0, 50); rb = $urandom_range(1, 9); end
        2: begin ra = 32'd0 - $urandom_range(0, 50); rb = 32'd0 - $urandom_range(1, 9); end
        3: rb = 32'($urandom_range(1, 1000));
        default: ;
      endcase
      model(ro, ra, rb, eh, el);
      run_op($sformatf("rand%0d op%0d %h/%h", k, ro, ra, rb), ro, ra, rb, eh, el);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
